// File: rtl/interrupt_dispatch_pkg.sv
// rtl/interrupt_dispatch_pkg.sv - shared source indices, addresses, state enum and vector helpers
package interrupt_dispatch_pkg;

   // Interrupt source indices; lower index means higher priority
   localparam logic [2:0] INT_VBLANK  = 3'd0;
   localparam logic [2:0] INT_LCDSTAT = 3'd1;
   localparam logic [2:0] INT_TIMER   = 3'd2;
   localparam logic [2:0] INT_SERIAL  = 3'd3;
   localparam logic [2:0] INT_JOYPAD  = 3'd4;

   // Memory-mapped locations of the flag and enable registers
   localparam logic [15:0] IF_ADDR = 16'hFF0F;
   localparam logic [15:0] IE_ADDR = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_PUSH_HI,
      ST_PUSH_LO,
      ST_JUMP
   } dispatch_state_t;

   // Vectors are spaced 8 bytes apart starting at the base
   function automatic logic [15:0] vector_addr(input logic [15:0] base, input logic [2:0] idx);
      return base + {10'd0, idx, 3'b000};
   endfunction

   // One-hot mask for a source index
   function automatic logic [4:0] src_mask(input logic [2:0] idx);
      logic [4:0] m;
      m = 5'b00001 << idx;
      return m;
   endfunction

endpackage

// File: rtl/interrupt_dispatch_int_priority_enc.sv
// rtl/interrupt_dispatch_int_priority_enc.sv - fixed-priority encoder, lowest pending bit wins
module int_priority_enc
   import interrupt_dispatch_pkg::*;
(
   input  logic [4:0] pend,
   output logic [2:0] idx,
   output logic       valid
);

   // Pick the lowest set bit; valid drops when nothing is pending
   always_comb begin
      idx   = INT_VBLANK;
      valid = 1'b1;
      if (pend[0])      idx = INT_VBLANK;
      else if (pend[1]) idx = INT_LCDSTAT;
      else if (pend[2]) idx = INT_TIMER;
      else if (pend[3]) idx = INT_SERIAL;
      else if (pend[4]) idx = INT_JOYPAD;
      else              valid = 1'b0;
   end

endmodule

// File: rtl/interrupt_dispatch.sv
// rtl/interrupt_dispatch.sv - IME handling, priority dispatch sequence and IF write-back; option macro INT_LATE_RESAMPLE_EN
module interrupt_dispatch
   import interrupt_dispatch_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] VECTOR_BASE = 16'h0040
) (
   input  logic        I_CLOCK,
   input  logic        I_RESET,
   input  logic [4:0]  I_IF,
   input  logic [4:0]  I_IE,
   input  logic        I_INSTR_DONE,
   input  logic        I_EI,
   input  logic        I_DI,
   input  logic        I_RETI,
   input  logic [15:0] I_PC,
   input  logic [15:0] I_SP,
   input  logic        I_MEM_READY,
   output logic        O_BUSY,
   output logic        O_MEM_WE_L,
   output logic [15:0] O_MEM_ADDR,
   output logic [7:0]  O_MEM_DATA,
   output logic [15:0] O_SP,
   output logic        O_SP_LOAD,
   output logic [15:0] O_PC,
   output logic        O_PC_LOAD,
   output logic [4:0]  O_IF,
   output logic        O_IF_LOAD,
   output logic [4:0]  O_ACK,
   output logic        O_WAKE,
   output logic        O_IME
);

   // Last value of the wait counter; unused when the wait phase is skipped
   localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES - 1);

   dispatch_state_t state;
   logic            ime;
   logic            ei_pending;
   logic [2:0]      wait_cnt;
   logic [2:0]      idx_q;
   logic [15:0]     pc_q;
   logic [15:0]     sp_q;
   logic            cancel_q;
   logic            if_load_q;
   logic [4:0]      pend;
   logic [2:0]      enc_idx;
   logic            enc_valid;
   logic            accept;

   assign pend   = I_IF & I_IE & 5'h1F;
   assign accept = (state == ST_IDLE) && I_INSTR_DONE && ime && enc_valid;

   int_priority_enc u_prio (
      .pend  (pend),
      .idx   (enc_idx),
      .valid (enc_valid)
   );

   // IME and the one-instruction EI delay; retire events are ignored while a dispatch runs
   always_ff @(posedge I_CLOCK) begin
      if (I_RESET) begin
         ime        <= 1'b0;
         ei_pending <= 1'b0;
      end else if (accept) begin
         // Accepting a dispatch clears IME and never promotes a pending EI
         ime <= 1'b0;
         if (I_DI || I_RETI) ei_pending <= 1'b0;
         else if (I_EI)      ei_pending <= 1'b1;
      end else if (!O_BUSY) begin
         if (I_DI) begin
            ime        <= 1'b0;
            ei_pending <= 1'b0;
         end else if (I_RETI) begin
            ime        <= 1'b1;
            ei_pending <= 1'b0;
         end else if (I_EI) begin
            ei_pending <= 1'b1;
         end else if (ei_pending && I_INSTR_DONE) begin
            ime        <= 1'b1;
            ei_pending <= 1'b0;
         end
      end
   end

   // Dispatch sequencer: wait, push PC high, push PC low, jump; all bus and load outputs registered
   always_ff @(posedge I_CLOCK) begin
      if (I_RESET) begin
         state      <= ST_IDLE;
         wait_cnt   <= 3'd0;
         idx_q      <= 3'd0;
         pc_q       <= 16'd0;
         sp_q       <= 16'd0;
         cancel_q   <= 1'b0;
         if_load_q  <= 1'b0;
         O_BUSY     <= 1'b0;
         O_MEM_WE_L <= 1'b1;
         O_MEM_ADDR <= 16'd0;
         O_MEM_DATA <= 8'd0;
         O_SP       <= 16'd0;
         O_SP_LOAD  <= 1'b0;
         O_PC       <= 16'd0;
         O_PC_LOAD  <= 1'b0;
         O_ACK      <= 5'd0;
      end else begin
         O_SP_LOAD <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  O_BUSY   <= 1'b1;
                  idx_q    <= enc_idx;
                  pc_q     <= I_PC;
                  sp_q     <= I_SP;
                  cancel_q <= 1'b0;
                  wait_cnt <= 3'd0;
                  if (WAIT_CYCLES == 0) begin
                     state      <= ST_PUSH_HI;
                     O_MEM_WE_L <= 1'b0;
                     O_MEM_ADDR <= I_SP - 16'd1;
                     O_MEM_DATA <= I_PC[15:8];
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state      <= ST_PUSH_HI;
                  O_MEM_WE_L <= 1'b0;
                  O_MEM_ADDR <= sp_q - 16'd1;
                  O_MEM_DATA <= pc_q[15:8];
               end else begin
                  wait_cnt <= wait_cnt + 3'd1;
               end
            end
            ST_PUSH_HI: begin
               // Address and data stay put until the bus takes the write
               if (I_MEM_READY) begin
                  O_SP       <= sp_q - 16'd1;
                  O_SP_LOAD  <= 1'b1;
                  O_MEM_ADDR <= sp_q - 16'd2;
                  O_MEM_DATA <= pc_q[7:0];
                  state      <= ST_PUSH_LO;
`ifdef INT_LATE_RESAMPLE_EN
                  idx_q    <= enc_idx;
                  cancel_q <= !enc_valid;
`else
                  cancel_q <= 1'b0;
`endif
               end
            end
            ST_PUSH_LO: begin
               if (I_MEM_READY) begin
                  O_SP       <= sp_q - 16'd2;
                  O_SP_LOAD  <= 1'b1;
                  O_MEM_WE_L <= 1'b1;
                  O_PC_LOAD  <= 1'b1;
                  state      <= ST_JUMP;
                  if (cancel_q) begin
                     O_PC      <= 16'h0000;
                     O_ACK     <= 5'd0;
                     if_load_q <= 1'b0;
                  end else begin
                     O_PC      <= vector_addr(VECTOR_BASE, idx_q);
                     O_ACK     <= src_mask(idx_q);
                     if_load_q <= 1'b1;
                  end
               end
            end
            ST_JUMP: begin
               O_PC_LOAD <= 1'b0;
               O_ACK     <= 5'd0;
               if_load_q <= 1'b0;
               O_BUSY    <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // IF write-back samples live IF during the jump cycle so sets on other bits are kept
   assign O_IF      = if_load_q ? (I_IF & ~O_ACK) : 5'd0;
   assign O_IF_LOAD = if_load_q;
   assign O_WAKE    = |(I_IF & I_IE);
   assign O_IME     = ime;

endmodule
